// File: rtl/adder_tree_pkg.sv
// Shared definitions for the float-to-fixed adder tree and its input collector.
// Holds the frame width, element width, the +0.0 pad word and the element and
// frame vector types used on the collector/tree boundary.
package adder_tree_pkg;

    localparam int NUM_ELEMENTS     = 50;
    localparam int DATA_WIDTH_float = 32;
    localparam int CNT_W            = $clog2(NUM_ELEMENTS + 1);

    typedef logic [DATA_WIDTH_float-1:0] float_t;
    typedef float_t                      float_vec_t [NUM_ELEMENTS];
    typedef logic [CNT_W-1:0]            cnt_t;

    localparam float_t FLOAT_ZERO = '0;

endpackage

// File: rtl/adder_tree_collect_bank.sv
// One bank of the collector's ping-pong buffer.
// Ports:
//   clk, rst     clock and synchronous active-high reset (control state only)
//   wr_en        store wr_data at the current fill position
//   wr_last      upstream marks this element as the end of its frame
//   wr_data      float32 element, stored bit-exact
//   rel          the presented frame has been taken; bank returns to empty
//   rd_data      stored frame, entries at or beyond count read as +0.0
//   count        number of elements held
//   short_flag   frame was closed by wr_last before the bank was full
//   full         bank holds a closed frame
//   close        this cycle's write closes the frame
module adder_tree_collect_bank
    import adder_tree_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic                        wr_last,
    input  logic [DATA_WIDTH_float-1:0] wr_data,
    input  logic                        rel,
    output logic [DATA_WIDTH_float-1:0] rd_data [NUM_ELEMENTS],
    output logic [CNT_W-1:0]            count,
    output logic                        short_flag,
    output logic                        full,
    output logic                        close
);

    localparam cnt_t LAST_IDX = cnt_t'(NUM_ELEMENTS - 1);

    logic [DATA_WIDTH_float-1:0] mem [NUM_ELEMENTS];

    assign close = wr_en && (wr_last || (count == LAST_IDX));

    // Storage is never reset; stale words are hidden by the count mask.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count] <= wr_data;
        end
    end

    // A bank is only written while not full and only released while full,
    // so rel and wr_en never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            full       <= 1'b0;
            short_flag <= 1'b0;
        end else if (rel) begin
            count      <= '0;
            full       <= 1'b0;
            short_flag <= 1'b0;
        end else if (wr_en) begin
            count <= count + cnt_t'(1);
            if (close) begin
                full       <= 1'b1;
                // count+1 < NUM_ELEMENTS is the same as not closing on the last slot
                short_flag <= (count != LAST_IDX);
            end
        end
    end

    for (genvar k = 0; k < NUM_ELEMENTS; k++) begin : g_rd
        assign rd_data[k] = (cnt_t'(k) < count) ? mem[k] : FLOAT_ZERO;
    end

endmodule

// File: rtl/adder_tree_input_collector.sv
// Serial-to-parallel collector in front of the float-to-fixed adder tree.
// Gathers one float32 per cycle into frames of NUM_ELEMENTS using two banks,
// so one frame can be held for the tree while the next one fills.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   in_data      float32 element
//   in_valid     in_data valid
//   in_last      final element of a frame (may come early)
//   in_ready     an element can be accepted this cycle
//   vec_out      presented frame, index 0 = first accepted, zero padded
//   vec_count    real elements in the presented frame
//   vec_short    presented frame was closed early by in_last
//   vec_valid    vec_out holds a complete frame
//   vec_ready    adder tree has taken the frame
module adder_tree_input_collector
    import adder_tree_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH_float-1:0] in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [DATA_WIDTH_float-1:0] vec_out [NUM_ELEMENTS],
    output logic [CNT_W-1:0]            vec_count,
    output logic                        vec_short,
    output logic                        vec_valid,
    input  logic                        vec_ready
);

    logic                        wr_bank;
    logic                        rd_bank;
    logic                        accept;
    logic                        release_frame;
    logic                        close_any;
    logic [1:0]                  wr_en_b;
    logic [1:0]                  rel_b;
    logic [1:0]                  full_b;
    logic [1:0]                  short_b;
    logic [1:0]                  close_b;
    logic [CNT_W-1:0]            count_0;
    logic [CNT_W-1:0]            count_1;
    logic [DATA_WIDTH_float-1:0] rd_0 [NUM_ELEMENTS];
    logic [DATA_WIDTH_float-1:0] rd_1 [NUM_ELEMENTS];

    // Ready comes from registered full flags only, so a release never
    // reaches in_ready in the same cycle.
    assign in_ready      = !rst && !full_b[wr_bank];
    assign accept        = in_valid && in_ready;
    assign release_frame = vec_valid && vec_ready;
    assign close_any     = |close_b;

    assign wr_en_b = {accept && wr_bank, accept && !wr_bank};
    assign rel_b   = {release_frame && rd_bank, release_frame && !rd_bank};

    adder_tree_collect_bank u_bank0 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en_b[0]),
        .wr_last    (in_last),
        .wr_data    (in_data),
        .rel        (rel_b[0]),
        .rd_data    (rd_0),
        .count      (count_0),
        .short_flag (short_b[0]),
        .full       (full_b[0]),
        .close      (close_b[0])
    );

    adder_tree_collect_bank u_bank1 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en_b[1]),
        .wr_last    (in_last),
        .wr_data    (in_data),
        .rel        (rel_b[1]),
        .rd_data    (rd_1),
        .count      (count_1),
        .short_flag (short_b[1]),
        .full       (full_b[1]),
        .close      (close_b[1])
    );

    // Close of one bank and release of the other may share an edge; each
    // pointer moves independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (close_any) begin
                wr_bank <= !wr_bank;
            end
            if (release_frame) begin
                rd_bank <= !rd_bank;
            end
        end
    end

    // Presentation is masked during reset so nothing stale leaks out on the
    // reset cycle itself.
    assign vec_valid = !rst && full_b[rd_bank];
    assign vec_short = !rst && short_b[rd_bank];
    assign vec_count = rst ? '0 : (rd_bank ? count_1 : count_0);

    for (genvar k = 0; k < NUM_ELEMENTS; k++) begin : g_out
        assign vec_out[k] = rd_bank ? rd_1[k] : rd_0[k];
    end

endmodule

// File: tb/tb_adder_tree_input_collector.sv
// Self-checking bench for adder_tree_input_collector. A frame-level model
// (pending frames in a queue, a partial frame being gathered) predicts the
// handshake and presented frame every cycle.
module tb_adder_tree_input_collector;
    import adder_tree_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [DATA_WIDTH_float-1:0] in_data;
    logic                        in_valid;
    logic                        in_last;
    logic                        in_ready;
    logic [DATA_WIDTH_float-1:0] vec_out [NUM_ELEMENTS];
    logic [CNT_W-1:0]            vec_count;
    logic                        vec_short;
    logic                        vec_valid;
    logic                        vec_ready;

    adder_tree_input_collector dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .vec_out   (vec_out),
        .vec_count (vec_count),
        .vec_short (vec_short),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          accepted;
    int          frame_len  [$];
    logic [31:0] frame_data [$];
    logic [31:0] cur        [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check outputs mid-cycle, then advance the model by this cycle's edge.
    task automatic cycle();
        int n;
        bit exp_rdy;
        bit exp_vld;
        n = 0;
        @(negedge clk);
        if (rst) begin
            chk("in_ready_rst",  32'(in_ready),  32'd0);
            chk("vec_valid_rst", 32'(vec_valid), 32'd0);
            chk("vec_count_rst", 32'(vec_count), 32'd0);
            chk("vec_short_rst", 32'(vec_short), 32'd0);
            frame_len.delete();
            frame_data.delete();
            cur.delete();
            accepted = 1'b0;
        end else begin
            exp_rdy = frame_len.size() < 2;
            exp_vld = frame_len.size() > 0;
            chk("in_ready",  32'(in_ready),  32'(exp_rdy));
            chk("vec_valid", 32'(vec_valid), 32'(exp_vld));
            if (exp_vld) begin
                n = frame_len[0];
                chk("vec_count", 32'(vec_count), 32'(n));
                chk("vec_short", 32'(vec_short), 32'(n < NUM_ELEMENTS));
                for (int k = 0; k < NUM_ELEMENTS; k++) begin
                    chk($sformatf("vec_out[%0d]", k), vec_out[k],
                        (k < n) ? frame_data[k] : 32'h0000_0000);
                end
            end
            accepted = in_valid && exp_rdy;
            if (exp_vld && vec_ready) begin
                for (int k = 0; k < n; k++) void'(frame_data.pop_front());
                void'(frame_len.pop_front());
            end
            if (accepted) begin
                cur.push_back(in_data);
                if (in_last || cur.size() == NUM_ELEMENTS) begin
                    frame_len.push_back(cur.size());
                    foreach (cur[i]) frame_data.push_back(cur[i]);
                    cur.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        do begin
            cycle();
            guard++;
        end while (!accepted && guard < 300);
        chk("send_accept", 32'(accepted), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        int idx;
        int guard;
        int len;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        vec_ready = 1'b0;
        accepted  = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cycle();
        rst = 1'b0;
        idle(2);

        // Full frame of 1.0, released as soon as presented.
        vec_ready = 1'b1;
        for (int i = 0; i < NUM_ELEMENTS; i++) send(32'h3F80_0000, i == NUM_ELEMENTS - 1);
        idle(3);

        // Short frame of 3.0 closed by in_last.
        for (int i = 0; i < 10; i++) send(32'h4040_0000, i == 9);
        idle(3);

        // 150-element index stream with the tree stalled.
        vec_ready = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < 100 && guard < 400) begin
            in_valid = 1'b1; in_data = 32'(idx); in_last = 1'b0;
            cycle();
            if (accepted) idx++;
            guard++;
        end
        in_valid = 1'b1; in_data = 32'(idx);
        repeat (3) cycle();
        vec_ready = 1'b1;
        cycle();
        vec_ready = 1'b0;
        while (idx < 150 && guard < 800) begin
            in_valid = 1'b1; in_data = 32'(idx); in_last = 1'b0;
            cycle();
            if (accepted) idx++;
            guard++;
        end
        chk("stream_count", 32'(idx), 32'd150);
        vec_ready = 1'b1;
        idle(4);

        // Back-to-back tiny frames: closes and releases share edges.
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) send($urandom, i == len - 1);
        end
        idle(4);

        // Reset with one frame presented and a second half filled.
        vec_ready = 1'b0;
        for (int i = 0; i < NUM_ELEMENTS; i++) send(32'h1000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 25; i++) send(32'h2000_0000 + 32'(i), 1'b0);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        vec_ready = 1'b1;
        idle(1);
        for (int i = 0; i < NUM_ELEMENTS; i++) send(32'h3000_0000 + 32'(i), 1'b0);
        idle(3);

        // One-element frame.
        send(32'hBF80_0000, 1'b1);
        idle(3);

        // Random traffic with upstream holding data while stalled.
        in_valid = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            vec_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            if (!in_valid || accepted) begin
                in_valid = $urandom_range(0, 1) != 0;
                in_data  = $urandom;
                in_last  = ($urandom_range(0, 15) == 0);
            end
            cycle();
        end
        rst = 1'b0;
        vec_ready = 1'b1;
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
